// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared multiplier mode encodings, widths and product helper
package mult_pkg;

  localparam int OPW   = 16;
  localparam int PRODW = 32;

  typedef enum logic [1:0] {
    MODE_U8  = 2'd0,
    MODE_S8  = 2'd1,
    MODE_S16 = 2'd2,
    MODE_U16 = 2'd3
  } mode_e;

  // Operands are widened explicitly so every product is computed at its final width.
  function automatic logic [PRODW-1:0] mult_compute(
    input mode_e          mode,
    input logic [OPW-1:0] a,
    input logic [OPW-1:0] b
  );
    logic [15:0]      p8;
    logic [PRODW-1:0] r;
    p8 = '0;
    r  = '0;
    case (mode)
      MODE_U8: begin
        p8 = {8'b0, a[7:0]} * {8'b0, b[7:0]};
        r  = {16'b0, p8};
      end
      MODE_S8: begin
        p8 = $signed({{8{a[7]}}, a[7:0]}) * $signed({{8{b[7]}}, b[7:0]});
        r  = {{16{p8[15]}}, p8};
      end
      MODE_S16: r = $signed({{16{a[15]}}, a}) * $signed({{16{b[15]}}, b});
      default:  r = {16'b0, a} * {16'b0, b};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin grant selection starting at a pointer
module rr_arbiter
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            enable,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx
);

  // Pick the active requester with the smallest circular distance from ptr.
  always_comb begin
    int best_d;
    int best_i;
    int d;
    best_d    = NREQ;
    best_i    = 0;
    d         = 0;
    grant     = '0;
    grant_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      d = i - int'(ptr);
      if (d < 0) d = d + NREQ;
      if (req[i] && (d < best_d)) begin
        best_d = d;
        best_i = i;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      grant[i] = enable && (best_d < NREQ) && (best_i == i);
    end
    if (enable && (best_d < NREQ)) grant_idx = IDW'(best_i);
  end

endmodule

// File: rtl/mult_arbiter.sv
// rtl/mult_arbiter.sv - round-robin shared two-stage multiplier
module mult_arbiter
  import mult_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [2*NREQ-1:0]   req_mode,
  input  logic [OPW*NREQ-1:0] req_a,
  input  logic [OPW*NREQ-1:0] req_b,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [IDW-1:0]      res_id,
  output logic [PRODW-1:0]    res_product,
  output logic                busy,
  output logic [15:0]         done_count
);

  logic             s1_valid;
  mode_e            s1_mode;
  logic [OPW-1:0]   s1_a;
  logic [OPW-1:0]   s1_b;
  logic [IDW-1:0]   s1_id;
  logic [PRODW-1:0] s1_product;
  logic [IDW-1:0]   ptr;
  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   grant_idx;
  logic             s2_ready;
  logic             s1_ready;
  logic             arb_enable;
  logic [1:0]       sel_mode;
  logic [OPW-1:0]   sel_a;
  logic [OPW-1:0]   sel_b;

  // Stage 2 frees when empty or handing off; stage 1 frees when empty or moving into stage 2.
  assign s2_ready   = !res_valid || res_ready;
  assign s1_ready   = !s1_valid || s2_ready;
  assign arb_enable = reset && s1_ready;
  assign req_ready  = grant;
  assign busy       = s1_valid || res_valid;
  assign s1_product = mult_compute(s1_mode, s1_a, s1_b);

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
    .req       (req_valid),
    .ptr       (ptr),
    .enable    (arb_enable),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Route the granted requester's mode and operands toward stage 1.
  always_comb begin
    sel_mode = '0;
    sel_a    = '0;
    sel_b    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_mode = req_mode[2*i +: 2];
        sel_a    = req_a[OPW*i +: OPW];
        sel_b    = req_b[OPW*i +: OPW];
      end
    end
  end

  // Round-robin pointer moves past the winner only when a grant is issued.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (|grant) begin
      ptr <= (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + IDW'(1);
    end
  end

  // Stage 1 captures the accepted request whenever it is free to load.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_mode  <= MODE_U8;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_id    <= '0;
    end else if (s1_ready) begin
      s1_valid <= |grant;
      if (|grant) begin
        s1_mode <= mode_e'(sel_mode);
        s1_a    <= sel_a;
        s1_b    <= sel_b;
        s1_id   <= grant_idx;
      end
    end
  end

  // Stage 2 holds the product and owner steady until the consumer takes it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      res_valid   <= 1'b0;
      res_id      <= '0;
      res_product <= '0;
    end else if (s2_ready) begin
      res_valid <= s1_valid;
      if (s1_valid) begin
        res_id      <= s1_id;
        res_product <= s1_product;
      end
    end
  end

  // Count result handoffs; the counter wraps naturally at 16 bits.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      done_count <= '0;
    end else if (res_valid && res_ready) begin
      done_count <= done_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// tb/tb_mult_arbiter.sv - directed self-checking bench for mult_arbiter
module tb_mult_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clock = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [2*NREQ-1:0] req_mode;
  logic [16*NREQ-1:0] req_a;
  logic [16*NREQ-1:0] req_b;
  logic              res_valid;
  logic              res_ready;
  logic [IDW-1:0]    res_id;
  logic [31:0]       res_product;
  logic              busy;
  logic [15:0]       done_count;

  mult_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_mode    (req_mode),
    .req_a       (req_a),
    .req_b       (req_b),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_id      (res_id),
    .res_product (res_product),
    .busy        (busy),
    .done_count  (done_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          id;
    logic [1:0]  mode;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] prod;
  } vec_t;

  vec_t vecs[11];
  int   total = 0;
  int   bad   = 0;
  int   ptr_m = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input int id, input logic [1:0] m, input logic [15:0] a, input logic [15:0] b);
    req_mode[2*id +: 2] = m;
    req_a[16*id +: 16]  = a;
    req_b[16*id +: 16]  = b;
  endtask

  function automatic int rr_pick(input logic [3:0] pend, input int p);
    for (int off = 0; off < 4; off++) begin
      int i;
      i = (p + off) % 4;
      if (pend[i]) return i;
    end
    return -1;
  endfunction

  initial begin
    logic [3:0] pending;
    int         e;
    int         rcount;
    int         stall_acc;
    int         grants;
    int         exp_id[$];
    logic [31:0] exp_p[$];

    vecs[0]  = '{2, 2'd0, 16'h00FF, 16'h00FF, 32'h0000FE01};
    vecs[1]  = '{1, 2'd1, 16'h0080, 16'h0002, 32'hFFFFFF00};
    vecs[2]  = '{2, 2'd2, 16'hFFFF, 16'h0003, 32'hFFFFFFFD};
    vecs[3]  = '{3, 2'd3, 16'hFFFF, 16'h0003, 32'h0002FFFD};
    vecs[4]  = '{0, 2'd0, 16'hAB12, 16'hCD10, 32'h00000120};
    vecs[5]  = '{1, 2'd1, 16'h12FF, 16'h34FF, 32'h00000001};
    vecs[6]  = '{2, 2'd1, 16'h007F, 16'h0080, 32'hFFFFC080};
    vecs[7]  = '{3, 2'd2, 16'h8000, 16'h8000, 32'h40000000};
    vecs[8]  = '{0, 2'd3, 16'hFFFF, 16'hFFFF, 32'hFFFE0001};
    vecs[9]  = '{1, 2'd2, 16'h7FFF, 16'h8000, 32'hC0008000};
    vecs[10] = '{2, 2'd0, 16'h0000, 16'h1234, 32'h00000000};

    reset     = 1'b0;
    req_valid = 4'hF;
    res_ready = 1'b1;
    req_mode  = '0;
    req_a     = '0;
    req_b     = '0;

    repeat (2) @(negedge clock);
    check("reset_req_ready", req_ready, 0);
    check("reset_res_valid", res_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_done_count", done_count, 0);
    check("reset_res_id", res_id, 0);
    check("reset_res_product", res_product, 0);
    req_valid = 4'h0;
    reset     = 1'b1;

    // Fairness: all four requesters valid for eight cycles.
    for (int i = 0; i < 4; i++) drive(i, 2'd3, 16'(i + 1), 16'h1000);
    rcount = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      req_valid = (c < 8) ? 4'hF : 4'h0;
      #1;
      if (c < 8) check("fair_grant", req_ready, 32'(1 << (c % 4)));
      if (c == 1) check("fair_busy", busy, 1);
      check("fair_res_valid", res_valid, (c >= 2 && c <= 9) ? 1 : 0);
      if (res_valid) begin
        check("fair_res_id", res_id, rcount % 4);
        check("fair_res_product", res_product, ((rcount % 4) + 1) << 12);
        rcount++;
      end
    end
    check("fair_done_count", done_count, 8);
    ptr_m = 0;

    // Single-request vectors covering every mode and the latency.
    for (int v = 0; v < 11; v++) begin
      @(negedge clock);
      drive(vecs[v].id, vecs[v].mode, vecs[v].a, vecs[v].b);
      req_valid = 4'(1 << vecs[v].id);
      #1;
      check("vec_grant", req_ready, 32'(1 << vecs[v].id));
      @(negedge clock);
      req_valid = 4'h0;
      #1;
      check("vec_early_res_valid", res_valid, 0);
      @(negedge clock);
      #1;
      check("vec_res_valid", res_valid, 1);
      check("vec_res_id", res_id, vecs[v].id);
      check("vec_res_product", res_product, vecs[v].prod);
      ptr_m = (vecs[v].id + 1) % 4;
    end
    @(negedge clock);
    check("vec_done_count", done_count, 19);

    // Backpressure: three pending requests, consumer stalled for five cycles.
    for (int i = 0; i < 3; i++) drive(i, 2'd0, 16'(i + 3), 16'h0005);
    pending   = 4'b0111;
    rcount    = 0;
    stall_acc = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clock);
      req_valid = pending;
      res_ready = (c >= 5);
      #1;
      if (c == 3) begin
        check("bp_busy", busy, 1);
        check("bp_stall_ready", req_ready, 0);
      end
      if (res_valid) begin
        if (exp_id.size() == 0) begin
          check("bp_unexpected_res_valid", res_valid, 0);
        end else begin
          check("bp_res_id", res_id, exp_id[0]);
          check("bp_res_product", res_product, exp_p[0]);
          if (res_ready) begin
            void'(exp_id.pop_front());
            void'(exp_p.pop_front());
            rcount++;
          end
        end
      end
      if (req_ready != 0) begin
        e = rr_pick(pending, ptr_m);
        if (e < 0) begin
          check("bp_spurious_grant", req_ready, 0);
        end else begin
          check("bp_grant", req_ready, 32'(1 << e));
          if (c < 5) stall_acc++;
          exp_id.push_back(e);
          exp_p.push_back(32'((e + 3) * 5));
          pending[e] = 1'b0;
          ptr_m = (e + 1) % 4;
        end
      end
    end
    check("bp_accept_during_stall", stall_acc, 2);
    check("bp_results", rcount, 3);
    check("bp_idle_after", busy, 0);

    // Reset with both stages full.
    for (int i = 0; i < 4; i++) drive(i, 2'd0, 16'h0007, 16'h0006);
    res_ready = 1'b0;
    req_valid = 4'hF;
    repeat (3) @(negedge clock);
    #1;
    check("rst_full_before", busy, 1);
    reset = 1'b0;
    #1;
    check("rst_res_valid", res_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done_count", done_count, 0);
    check("rst_req_ready", req_ready, 0);
    repeat (2) @(negedge clock);
    req_valid = 4'b1010;
    res_ready = 1'b1;
    reset     = 1'b1;
    #1;
    check("rst_first_grant", req_ready, 32'b0010);
    @(negedge clock);
    req_valid = 4'h0;
    rcount    = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (res_valid) begin
        check("rst_res_id", res_id, 1);
        check("rst_res_product", res_product, 42);
        rcount++;
      end
      @(negedge clock);
    end
    check("rst_result_count", rcount, 1);
    check("rst_done_count_after", done_count, 1);

    // done_count wrap: bring it to 0xFFFF, then one more handoff.
    grants = 0;
    for (int c = 0; c < 70000 && grants < 65534; c++) begin
      @(negedge clock);
      req_valid = 4'b0001;
      #1;
      if (req_ready[0]) grants++;
    end
    @(negedge clock);
    req_valid = 4'h0;
    check("wrap_grants", grants, 65534);
    for (int c = 0; c < 10 && busy; c++) @(negedge clock);
    check("wrap_drained", busy, 0);
    check("wrap_ffff", done_count, 32'h0000FFFF);
    @(negedge clock);
    req_valid = 4'b0001;
    @(negedge clock);
    req_valid = 4'h0;
    repeat (3) @(negedge clock);
    check("wrap_zero", done_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
